// File: rtl/riscv_imm_gen_pipe.sv
// Registered RISC-V immediate-generation stage with a 2-entry skid buffer.
// Define RISCV_IMM_TARGET_EN to register pc + imm into out_target; otherwise out_target stays 0.
module riscv_imm_gen_pipe #(
  parameter int WORD_LENGTH = 32,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [WORD_LENGTH-1:0] in_pc,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [WORD_LENGTH-1:0] out_pc,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [2:0]             out_fmt,
  output logic [WORD_LENGTH-1:0] out_imm,
  output logic [WORD_LENGTH-1:0] out_target
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0]            inst;
    logic [WORD_LENGTH-1:0] pc;
    logic [TAG_WIDTH-1:0]   tag;
    logic [2:0]             fmt;
    logic [WORD_LENGTH-1:0] imm;
    logic [WORD_LENGTH-1:0] target;
  } entry_t;

  entry_t             out_q, skid_q, dec_entry;
  logic               skid_valid;
  logic               in_fire;
  logic [2:0]         dec_fmt;
  logic signed [31:0] dec_raw;
  logic [WORD_LENGTH-1:0] dec_imm, dec_target;

  // Every immediate except Z fits in 32 signed bits; widen once at the end.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_raw = '0;
    dec_imm = '0;
    case (in_inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_raw = 32'($signed(in_inst[31:20]));
      end
      OP_SYSTEM: begin
        if (in_inst[14]) begin
          dec_fmt = FMT_Z;
        end else begin
          dec_fmt = FMT_I;
          dec_raw = 32'($signed(in_inst[31:20]));
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_raw = 32'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_raw = 32'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_raw = 32'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_raw = $signed({in_inst[31:12], 12'b0});
      end
      default: dec_fmt = FMT_NONE;
    endcase
    if (dec_fmt == FMT_Z) dec_imm = WORD_LENGTH'(in_inst[19:15]);
    else                  dec_imm = WORD_LENGTH'(dec_raw);
  end

`ifdef RISCV_IMM_TARGET_EN
  assign dec_target = in_pc + dec_imm;
`else
  assign dec_target = '0;
`endif

  always_comb begin
    dec_entry        = '0;
    dec_entry.inst   = in_inst;
    dec_entry.pc     = in_pc;
    dec_entry.tag    = in_tag;
    dec_entry.fmt    = dec_fmt;
    dec_entry.imm    = dec_imm;
    dec_entry.target = dec_target;
  end

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;

  // Output register refills when empty or draining; skid catches the one
  // entry that arrives while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_q     <= dec_entry;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= dec_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_inst   = out_q.inst;
  assign out_pc     = out_q.pc;
  assign out_tag    = out_q.tag;
  assign out_fmt    = out_q.fmt;
  assign out_imm    = out_q.imm;
  assign out_target = out_q.target;

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// Scoreboard bench for riscv_imm_gen_pipe: 32-bit main instance plus a 64-bit instance.
module tb_riscv_imm_gen_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_inst, out_pc, out_imm, out_target;
  logic [3:0]  in_tag, out_tag;
  logic [2:0]  out_fmt;

  logic        w_in_valid, w_in_ready, w_out_valid;
  logic [31:0] w_in_inst, w_out_inst;
  logic [63:0] w_in_pc, w_out_pc, w_out_imm, w_out_target;
  logic [3:0]  w_in_tag, w_out_tag;
  logic [2:0]  w_out_fmt;

  riscv_imm_gen_pipe #(.WORD_LENGTH(32), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_tag(out_tag), .out_fmt(out_fmt), .out_imm(out_imm), .out_target(out_target)
  );

  riscv_imm_gen_pipe #(.WORD_LENGTH(64), .TAG_WIDTH(4)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst), .in_pc(w_in_pc), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_inst(w_out_inst), .out_pc(w_out_pc),
    .out_tag(w_out_tag), .out_fmt(w_out_fmt), .out_imm(w_out_imm), .out_target(w_out_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic fired;
  logic rnd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
    exp_t e;
    logic [12:0] b;
    logic [20:0] j;
    e.inst = i; e.pc = p; e.tag = t; e.fmt = 3'd0; e.imm = 32'd0;
    b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin e.fmt = 3'd1; e.imm = 32'($signed(i) >>> 20); end
      7'h73: begin
        if (i[14]) begin e.fmt = 3'd6; e.imm = {27'd0, i[19:15]}; end
        else       begin e.fmt = 3'd1; e.imm = 32'($signed(i) >>> 20); end
      end
      7'h23: begin e.fmt = 3'd2; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h63: begin e.fmt = 3'd3; e.imm = {{19{b[12]}}, b}; end
      7'h6F: begin e.fmt = 3'd4; e.imm = {{11{j[20]}}, j}; end
      7'h37, 7'h17: begin e.fmt = 3'd5; e.imm = i & 32'hFFFF_F000; end
      default: ;
    endcase
`ifdef RISCV_IMM_TARGET_EN
    e.tgt = p + e.imm;
`else
    e.tgt = 32'd0;
`endif
    return e;
  endfunction

  // One clock: observe at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    fired = 1'b0;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(out_tag), 64'hDEAD);
        end else begin
          chk("out_inst", 64'(out_inst), 64'(sb[0].inst));
          chk("out_pc",   64'(out_pc),   64'(sb[0].pc));
          chk("out_tag",  64'(out_tag),  64'(sb[0].tag));
          chk("out_fmt",  64'(out_fmt),  64'(sb[0].fmt));
          chk("out_imm",  64'(out_imm),  64'(sb[0].imm));
          chk("out_tgt",  64'(out_target), 64'(sb[0].tgt));
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_inst, in_pc, in_tag));
        fired = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [3:0] t, output int waited);
    in_valid = 1'b1; in_inst = i; in_pc = p; in_tag = t; waited = 0;
    while (1) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      waited++;
      if (fired) break;
      if (waited > 40) begin chk("send_timeout", 64'(waited), 64'd0); break; end
    end
    in_valid = 1'b0;
  endtask

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F};

  initial begin
    int w;
    logic [31:0] ri;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_tag = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_inst = '0; w_in_pc = '0; w_in_tag = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_fmt_imm",   {29'd0, out_fmt, out_imm}, 64'd0);
    chk("rst_tgt_tag",   {28'd0, out_tag, out_target}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    cycle();

    send(32'hFFF00093, 32'h0, 4'd0, w);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_fmt",   64'(out_fmt),   64'd1);
    chk("lat_imm",   64'(out_imm),   64'hFFFF_FFFF);

    send(32'h008000EF, 32'h100, 4'd1, w);
    chk("tput_jal", 64'(w), 64'd1);
    send(32'hFE000EE3, 32'h200, 4'd2, w);
    chk("tput_branch", 64'(w), 64'd1);
    chk("b_imm", 64'(out_imm), 64'hFFFF_FFFC);
    send(32'h12345037, 32'h300, 4'd3, w);
    chk("tput_lui", 64'(w), 64'd1);
    send(32'h000FD073, 32'h304, 4'd4, w);
    chk("z_imm", 64'(out_imm), 64'h1F);
    send(32'h00000033, 32'h308, 4'd5, w);
    chk("none_fmt", 64'(out_fmt), 64'd0);
    repeat (2) cycle();

    out_ready = 1'b0;
    send(32'h00A00113, 32'h400, 4'd1, w);
    send(32'h00B00193, 32'h404, 4'd2, w);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_inst = 32'h00C00213; in_pc = 32'h408; in_tag = 4'd3;
    repeat (3) begin
      cycle();
      chk("bp_hold", 64'(fired), 64'd0);
      chk("bp_head_tag", 64'(out_tag), 64'd1);
    end
    out_ready = 1'b1;
    w = 0;
    while (!fired && w < 20) begin cycle(); w++; end
    chk("bp_tag3_accepted", 64'(fired), 64'd1);
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("bp_drained", 64'(sb.size()), 64'd0);

    rnd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      ri = $urandom();
      ri[6:0] = ops[$urandom_range(0, 10)];
      send(ri, $urandom(), 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 3) == 0) cycle();
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("rand_drained", 64'(sb.size()), 64'd0);

    out_ready = 1'b0;
    send(32'h00100093, 32'h500, 4'd7, w);
    send(32'h00200093, 32'h504, 4'd8, w);
    chk("pre_rst_skid_full", 64'(in_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
    @(posedge clk); #1; rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00900093, 32'h600, 4'd9, w);
    chk("post_rst_wait", 64'(w), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_tag", 64'(out_tag), 64'd9);
    repeat (3) cycle();
    chk("post_rst_empty", 64'(out_valid), 64'd0);

    w_in_valid = 1'b1; w_in_inst = 32'h800000B7; w_in_pc = 64'h1000;
    cycle();
    w_in_valid = 1'b0;
    chk("w64_valid", 64'(w_out_valid), 64'd1);
    chk("w64_fmt", 64'(w_out_fmt), 64'd5);
    chk("w64_imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);
`ifdef RISCV_IMM_TARGET_EN
    chk("w64_tgt", w_out_target, 64'hFFFF_FFFF_8000_1000);
`else
    chk("w64_tgt", w_out_target, 64'd0);
`endif
    w_in_valid = 1'b1; w_in_inst = 32'hFFF00093; w_in_pc = 64'h20;
    cycle();
    w_in_valid = 1'b0;
    chk("w64_i_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_imm_gen_pipe.md
Name: riscv_imm_gen_pipe

Overview:
- Registered immediate-generation stage placed between fetch and the decode/execute pipeline.
- Decodes the instruction format from the opcode and emits one selected, extended immediate with a format code and an optional PC-relative target.
- Moves instruction, PC and a sideband tag through a valid/ready handshake with a 2-entry skid buffer.
- Sustains full throughput with registered backpressure.

Parameters:
- WORD_LENGTH, 32, datapath width (32 or 64); all immediates are sign- or zero-extended to this width.
- TAG_WIDTH, 4, width of the opaque sideband tag carried alongside each instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- in_inst  input  32  raw instruction word.
- in_pc  input  WORD_LENGTH  PC of in_inst.
- in_tag  input  TAG_WIDTH  sideband tag, passed through unchanged.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_inst  output  32  registered instruction.
- out_pc  output  WORD_LENGTH  registered PC.
- out_tag  output  TAG_WIDTH  registered tag.
- out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 J, 5 U, 6 Z.
- out_imm  output  WORD_LENGTH  selected extended immediate.
- out_target  output  WORD_LENGTH  out_pc + out_imm (see Optional Feature).

Behaviour:
- Reset (async, active-high): out_valid=0, skid_valid=0, so in_ready=1; out_fmt=0, out_imm=0, out_target=0, out_inst=0, out_pc=0, out_tag=0; skid contents cleared.
- Format decode from inst[6:0]:
  - I: 0000011 (LOAD), 0010011 (OP-IMM), 1100111 (JALR).
  - SYSTEM 1110011: Z if inst[14]=1, else I.
  - S: 0100011. B: 1100011. J: 1101111. U: 0110111, 0010111.
  - Any other opcode: NONE with imm=0. No error is raised.
- Immediates:
  - I: inst[31:20], sign-extended.
  - S: {inst[31:25], inst[11:7]}, sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31 (relevant when WORD_LENGTH=64).
  - Z: inst[19:15], zero-extended.
- Decode and extension are computed combinationally on the input side and registered with the entry. Latency is 1 cycle from input handshake to out_valid.
- Handshakes: input transfer = in_valid and in_ready; output transfer = out_valid and out_ready.
- Output register load rule: loads when empty or when the current entry transfers out. Source is the skid entry if skid_valid, else the input.
- Skid capture: if the input transfers while the output register is full and not transferring, the entry goes into skid; skid_valid rises and in_ready drops next cycle.
- Skid drain: on output transfer with skid_valid, skid moves to the output register and skid_valid clears. A new input cannot transfer in that cycle, because in_ready was 0.
- Ordering is strict FIFO. No entry is dropped or duplicated. Output fields are stable while out_valid=1 and out_ready=0.
- Simultaneous input and output transfer with skid empty: the new entry replaces the output register and out_valid stays 1.
- out_ready=1 while out_valid=0 has no effect.
- Reset mid-operation discards all in-flight entries immediately (asynchronous).
- Arithmetic for out_target is modulo 2^WORD_LENGTH. No overflow flag.

Optional Feature:
- Macro: RISCV_IMM_TARGET_EN.
- Defined: an adder computes pc + imm on the input side and registers it with the entry into out_target, so it tracks out_imm with the same latency.
- Undefined: no adder is instantiated; out_target is constant 0 in all states.
- The handshake and every other output are identical with or without the macro.

Test Plan:
- Reset released, then inst 0xFFF00093, pc 0x0 -> 1 cycle later out_valid=1, fmt=1, imm=0xFFFFFFFF.
- Back-to-back with out_ready=1:
  - 0x008000EF, pc 0x100 -> fmt=4, imm=0x8, target=0x108 (macro on).
  - 0xFE000EE3, pc 0x200 -> fmt=3, imm=0xFFFFFFFC, target=0x1FC (macro on).
  - Throughput is one instruction per cycle.
- 0x12345037 -> fmt=5, imm=0x12345000. 0x000FD073 (csrrwi, zimm 31) -> fmt=6, imm=0x1F. 0x00000033 (OP) -> fmt=0, imm=0.
- Backpressure: out_ready=0, in_valid=1 with tags 1,2,3:
  - Tags 1 and 2 accepted, then in_ready=0 and tag 3 holds.
  - Raise out_ready -> tags emerge in order 1,2,3 with fields unchanged while stalled.
- Assert rst with the output register and skid both full -> out_valid=0 and in_ready=1 immediately. After release, the first new instruction appears after 1 cycle and stale tags never appear.
- WORD_LENGTH=64: 0x800000B7 (LUI) -> imm=0xFFFFFFFF80000000. Macro off -> out_target=0 for every input.
